// File: rtl/divider16bit8.sv
// divider16bit8 -- sequential restoring unsigned divider.
//
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor and produces one
// quotient bit per clock through a start/busy/done handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   start        request, sampled only while idle
//   dividend     2*WIDTH-bit dividend, captured on an accepted start
//   divisor      WIDTH-bit divisor, captured on an accepted start
//   busy         high while an operation is in progress
//   done         single-cycle completion pulse; results valid from this cycle
//   quot         quotient (all ones on an error completion)
//   rem          remainder (all ones on an error completion)
//   div_by_zero  set with done when the divisor was zero
//   overflow     set with done when the quotient would not fit in WIDTH bits
module divider16bit8 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quot,
    output logic [WIDTH-1:0]     rem,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] p;      // partial remainder; its top bit is always zero, so it is not stored
    logic [WIDTH-1:0] q;      // dividend low half shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dsr;    // captured divisor
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   p_shift;
    logic             qbit;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] q_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The difference always fits in WIDTH bits because p_shift < 2*dsr.
    always_comb begin
        p_shift = {p, q[WIDTH-1]};
        qbit    = (p_shift >= {1'b0, dsr});
        p_next  = qbit ? WIDTH'(p_shift - {1'b0, dsr}) : p_shift[WIDTH-1:0];
        q_next  = {q[WIDTH-2:0], qbit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            p           <= '0;
            q           <= '0;
            dsr         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dsr         <= divisor;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        // High half >= divisor means the quotient needs more than WIDTH bits.
                        if (divisor == '0 || dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                            state <= FINISH;
                        end else begin
                            state <= RUN;
                            p     <= dividend[2*WIDTH-1:WIDTH];
                            q     <= dividend[WIDTH-1:0];
                            cnt   <= '0;
                        end
                    end
                end
                RUN: begin
                    p   <= p_next;
                    q   <= q_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        quot  <= q_next;
                        rem   <= p_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                FINISH: begin
                    // Only two error kinds reach here; the captured divisor tells them apart.
                    quot        <= '1;
                    rem         <= '1;
                    div_by_zero <= (dsr == '0);
                    overflow    <= (dsr != '0);
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
